// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared widths, exec field positions, alu codes and forwarding helper
package execute_stage_pkg;
  localparam int NB_BITS = 32;
  localparam int NB_REG = 5;
  localparam int NB_CTR_EXEC = 6;
  localparam int NB_CTR_MEM = 3;
  localparam int NB_CTR_WB = 2;
  localparam int NB_MD_CNT = 6;
  localparam int EX_REG_DST = 5;
  localparam int EX_ALU_SRC = 4;
  localparam logic [1:0] FWD_EX_MEM = 2'd1;
  localparam logic [1:0] FWD_MEM_WB = 2'd2;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_MULT, ALU_DIV, ALU_MFHI, ALU_MFLO
  } alu_ctl_e;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;
  function automatic logic [NB_BITS-1:0] fwd_mux(input logic [1:0] sel,
      input logic [NB_BITS-1:0] id_ex, ex_mem, mem_wb);
    return sel == FWD_EX_MEM ? ex_mem : sel == FWD_MEM_WB ? mem_wb : id_ex;
  endfunction
endpackage

// File: rtl/execute_stage_muldiv.sv
// ex_muldiv_unit: iterative signed multiply/divide on magnitudes with HI/LO registers
module ex_muldiv_unit
  import execute_stage_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_div,
  input  logic [NB_BITS-1:0] i_a,
  input  logic [NB_BITS-1:0] i_b,
  output logic               o_busy,
  output logic [NB_BITS-1:0] o_hi,
  output logic [NB_BITS-1:0] o_lo
);
  md_state_e state, state_next;
  logic [NB_MD_CNT-1:0] cnt;
  logic div, sa, sb;
  logic [NB_BITS-1:0] mb, a_mag, b_mag, quot, rmd, hi_fix, lo_fix;
  logic [2*NB_BITS-1:0] p, p_step, prod;
  logic [NB_BITS:0] sum, rem, diff;
  always_comb begin
    a_mag = i_a[NB_BITS-1] ? -i_a : i_a;
    b_mag = i_b[NB_BITS-1] ? -i_b : i_b;
    // p holds {partial, multiplier} for MULT and {remainder, quotient} for DIV
    sum = {1'b0, p[2*NB_BITS-1:NB_BITS]} + (p[0] ? {1'b0, mb} : '0);
    rem = p[2*NB_BITS-1:NB_BITS-1];
    diff = rem - {1'b0, mb};
    p_step = div ? (diff[NB_BITS] ? {rem[NB_BITS-1:0], p[NB_BITS-2:0], 1'b0}
                                  : {diff[NB_BITS-1:0], p[NB_BITS-2:0], 1'b1})
                 : {sum, p[NB_BITS-1:1]};
    prod = (sa ^ sb) ? -p : p;
    quot = p[NB_BITS-1:0];
    rmd = p[2*NB_BITS-1:NB_BITS];
    hi_fix = div ? (sa ? -rmd : rmd) : prod[2*NB_BITS-1:NB_BITS];
    lo_fix = div ? (mb == '0 ? '1 : (sa ^ sb) ? -quot : quot) : prod[NB_BITS-1:0];
    state_next = state == MD_IDLE ? (i_start ? MD_RUN : MD_IDLE)
               : state == MD_RUN ? (cnt == NB_MD_CNT'(1) ? MD_DONE : MD_RUN) : MD_IDLE;
    o_busy = state != MD_IDLE;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= MD_IDLE;
      cnt <= '0;
      div <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      mb <= '0;
      p <= '0;
      o_hi <= '0;
      o_lo <= '0;
    end else begin
      state <= state_next;
      if (state == MD_IDLE && i_start) begin
        cnt <= NB_MD_CNT'(NB_BITS);
        div <= i_div;
        sa <= i_a[NB_BITS-1];
        sb <= i_b[NB_BITS-1];
        mb <= b_mag;
        p <= {{NB_BITS{1'b0}}, a_mag};
      end else if (state == MD_RUN) begin
        cnt <= cnt - 1'b1;
        p <= p_step;
      end else if (state == MD_DONE) begin
        o_hi <= hi_fix;
        o_lo <= lo_fix;
      end
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage with forwarding, ALU, mul/div unit and EX/MEM register
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NB_BITS-1:0]     i_id_ex_pc,
  input  logic [NB_BITS-1:0]     i_id_ex_rs,
  input  logic [NB_BITS-1:0]     i_id_ex_rt,
  input  logic [NB_BITS-1:0]     i_id_ex_sgext,
  input  logic [NB_CTR_EXEC-1:0] i_id_ex_exec,
  input  logic [NB_CTR_MEM-1:0]  i_id_ex_mem,
  input  logic [NB_CTR_WB-1:0]   i_id_ex_wb,
  input  logic [NB_REG-1:0]      i_id_ex_rt_num,
  input  logic [NB_REG-1:0]      i_id_ex_rd_num,
  input  logic [1:0]             i_fwd_a,
  input  logic [1:0]             i_fwd_b,
  input  logic [NB_BITS-1:0]     i_ex_mem_fwd,
  input  logic [NB_BITS-1:0]     i_mem_wb_fwd,
  output logic [NB_BITS-1:0]     o_ex_mem_alu,
  output logic [NB_BITS-1:0]     o_ex_mem_rt,
  output logic [NB_BITS-1:0]     o_ex_mem_pc,
  output logic [NB_REG-1:0]      o_ex_mem_reg_dst,
  output logic [NB_CTR_MEM-1:0]  o_ex_mem_mem,
  output logic [NB_CTR_WB-1:0]   o_ex_mem_wb,
  output logic                   o_ex_stall
);
  alu_ctl_e ctl;
  logic [NB_BITS-1:0] a, b_reg, b, alu, hi, lo;
  logic [4:0] shamt;
  logic bubble, md_busy, md_start, kill;
  always_comb begin
    ctl = alu_ctl_e'(i_id_ex_exec[3:0]);
    a = fwd_mux(i_fwd_a, i_id_ex_rs, i_ex_mem_fwd, i_mem_wb_fwd);
    b_reg = fwd_mux(i_fwd_b, i_id_ex_rt, i_ex_mem_fwd, i_mem_wb_fwd);
    b = i_id_ex_exec[EX_ALU_SRC] ? i_id_ex_sgext : b_reg;
    shamt = i_id_ex_sgext[10:6];
    bubble = ~|{i_id_ex_exec, i_id_ex_mem, i_id_ex_wb};
    o_ex_stall = md_busy && ctl >= ALU_MULT && !bubble;
    md_start = !md_busy && (ctl == ALU_MULT || ctl == ALU_DIV) && !bubble;
    // issuing MULT/DIV retires as a bubble, like a stalled HI/LO consumer
    kill = o_ex_stall || md_start;
  end
  always_comb begin
    alu = '0;
    case (ctl)
      ALU_ADD:  alu = a + b;
      ALU_SUB:  alu = a - b;
      ALU_AND:  alu = a & b;
      ALU_OR:   alu = a | b;
      ALU_XOR:  alu = a ^ b;
      ALU_NOR:  alu = ~(a | b);
      ALU_SLT:  alu = NB_BITS'($signed(a) < $signed(b));
      ALU_SLTU: alu = NB_BITS'(a < b);
      ALU_SLL:  alu = b << shamt;
      ALU_SRL:  alu = b >> shamt;
      ALU_SRA:  alu = $signed(b) >>> shamt;
      ALU_LUI:  alu = {b[15:0], 16'b0};
      ALU_MFHI: alu = hi;
      ALU_MFLO: alu = lo;
      default: ;
    endcase
  end
  ex_muldiv_unit u_muldiv (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(md_start),
    .i_div(ctl == ALU_DIV),
    .i_a(a),
    .i_b(b),
    .o_busy(md_busy),
    .o_hi(hi),
    .o_lo(lo)
  );
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_ex_mem_alu <= '0;
      o_ex_mem_rt <= '0;
      o_ex_mem_pc <= '0;
      o_ex_mem_reg_dst <= '0;
      o_ex_mem_mem <= '0;
      o_ex_mem_wb <= '0;
    end else begin
      o_ex_mem_alu <= alu;
      o_ex_mem_rt <= b_reg;
      o_ex_mem_pc <= i_id_ex_pc;
      o_ex_mem_reg_dst <= i_id_ex_exec[EX_REG_DST] ? i_id_ex_rd_num : i_id_ex_rt_num;
      o_ex_mem_mem <= kill ? '0 : i_id_ex_mem;
      o_ex_mem_wb <= kill ? '0 : i_id_ex_wb;
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and random stimulus against a behavioural EX-stage model
module tb_execute_stage;
  logic clk = 1'b0, rst;
  logic [31:0] pc, rs, rt, sg, exf, wbf;
  logic [5:0] exec;
  logic [2:0] mem;
  logic [1:0] wb, fa, fb;
  logic [4:0] rtn, rdn;
  logic [31:0] o_alu, o_rt, o_pc;
  logic [4:0] o_dst;
  logic [2:0] o_mem;
  logic [1:0] o_wb;
  logic o_stall;
  int checks = 0, errors = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi, p_lo;
  int md_left = 0;
  logic last_stall;
  int n;
  always #5 clk = ~clk;
  execute_stage dut (
    .i_clk(clk), .i_rst(rst), .i_id_ex_pc(pc), .i_id_ex_rs(rs), .i_id_ex_rt(rt),
    .i_id_ex_sgext(sg), .i_id_ex_exec(exec), .i_id_ex_mem(mem), .i_id_ex_wb(wb),
    .i_id_ex_rt_num(rtn), .i_id_ex_rd_num(rdn), .i_fwd_a(fa), .i_fwd_b(fb),
    .i_ex_mem_fwd(exf), .i_mem_wb_fwd(wbf), .o_ex_mem_alu(o_alu), .o_ex_mem_rt(o_rt),
    .o_ex_mem_pc(o_pc), .o_ex_mem_reg_dst(o_dst), .o_ex_mem_mem(o_mem),
    .o_ex_mem_wb(o_wb), .o_ex_stall(o_stall)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, b,
      input int sh, input logic [31:0] hi, lo);
    case (c)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a | b);
      6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      7: return (a < b) ? 32'd1 : 32'd0;
      8: return b << sh;
      9: return b >> sh;
      10: return 32'(int'(b) >>> sh);
      11: return b * 32'h1_0000;
      14: return hi;
      15: return lo;
      default: return 32'd0;
    endcase
  endfunction
  task automatic cycle();
    logic [31:0] a, bm, b, ea;
    logic bub, busy, stall, start, kill, r;
    longint q, rr;
    #1;
    a = fa == 1 ? exf : fa == 2 ? wbf : rs;
    bm = fb == 1 ? exf : fb == 2 ? wbf : rt;
    b = exec[4] ? sg : bm;
    bub = exec == 0 && mem == 0 && wb == 0;
    busy = md_left > 0;
    stall = busy && exec[3:0] >= 12 && !bub;
    start = !busy && (exec[3:0] == 12 || exec[3:0] == 13) && !bub;
    kill = stall || start;
    ea = ref_alu(exec[3:0], a, b, int'(sg[10:6]), m_hi, m_lo);
    r = rst;
    chk("stall", 32'(o_stall), 32'(stall));
    @(posedge clk);
    #1;
    if (r) begin
      chk("rst_alu", o_alu, 0);
      chk("rst_rt", o_rt, 0);
      chk("rst_pc", o_pc, 0);
      chk("rst_dst", 32'(o_dst), 0);
      chk("rst_mem", 32'(o_mem), 0);
      chk("rst_wb", 32'(o_wb), 0);
      md_left = 0;
      m_hi = 0;
      m_lo = 0;
    end else begin
      chk("mem", 32'(o_mem), kill ? 0 : 32'(mem));
      chk("wb", 32'(o_wb), kill ? 0 : 32'(wb));
      if (!kill) begin
        chk("alu", o_alu, ea);
        chk("rt", o_rt, bm);
        chk("pc", o_pc, pc);
        chk("dst", 32'(o_dst), 32'(exec[5] ? rdn : rtn));
      end
      if (busy) begin
        md_left--;
        if (md_left == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end else if (start) begin
        md_left = 33;
        if (exec[3:0] == 12) begin
          q = longint'(int'(a)) * longint'(int'(b));
          p_hi = q[63:32];
          p_lo = q[31:0];
        end else if (b == 0) begin
          p_hi = a;
          p_lo = 32'hFFFF_FFFF;
        end else begin
          q = longint'(int'(a)) / longint'(int'(b));
          rr = longint'(int'(a)) % longint'(int'(b));
          p_hi = rr[31:0];
          p_lo = q[31:0];
        end
      end
    end
    last_stall = stall;
  endtask
  task automatic op(input logic [3:0] c, input logic src, input logic [31:0] a, b, s);
    exec = {1'b1, src, c};
    rs = a;
    rt = b;
    sg = s;
    fa = 0;
    fb = 0;
    mem = 0;
    wb = 2'b01;
    pc = $urandom;
    exf = $urandom;
    wbf = $urandom;
    rtn = 5'($urandom);
    rdn = 5'($urandom);
  endtask
  task automatic read_hl(input logic [3:0] c, output int stalls);
    op(c, 0, 0, 0, 0);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      exf = $urandom;
      cycle();
      if (!last_stall) break;
      stalls++;
    end
  endtask
  task automatic rand_ins();
    op(4'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
    if ($urandom_range(0, 7) == 0) rt = $urandom_range(0, 3);
    if ($urandom_range(0, 7) == 0) rs = 32'h8000_0000;
    fa = 2'($urandom);
    fb = 2'($urandom);
    mem = 3'($urandom);
    wb = 2'($urandom);
    exec[5] = 1'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      exec = 0;
      mem = 0;
      wb = 0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1;
    op(0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 0;
    op(0, 0, 5, 3, 0);
    exf = 7;
    fa = 1;
    rdn = 9;
    rtn = 4;
    cycle();
    chk("add_fwd", o_alu, 10);
    chk("add_dst", 32'(o_dst), 9);
    chk("add_wb", 32'(o_wb), 1);
    op(10, 0, 0, 32'h8000_0000, 32'h100);
    cycle();
    chk("sra", o_alu, 32'hF800_0000);
    op(11, 1, 0, 0, 32'h1234);
    cycle();
    chk("lui", o_alu, 32'h1234_0000);
    op(6, 0, 32'hFFFF_FFFF, 1, 0);
    cycle();
    chk("slt", o_alu, 1);
    op(7, 0, 32'hFFFF_FFFF, 1, 0);
    cycle();
    chk("sltu", o_alu, 0);
    op(12, 0, 32'hFFFF_FFFD, 7, 0);
    wb = 0;
    cycle();
    read_hl(15, n);
    chk("mult_stalls", n, 33);
    chk("mult_lo", o_alu, 32'hFFFF_FFEB);
    read_hl(14, n);
    chk("mult_hi", o_alu, 32'hFFFF_FFFF);
    op(13, 0, 32'hFFFF_FFF9, 2, 0);
    cycle();
    repeat (33) begin
      op(0, 0, $urandom, $urandom, 0);
      cycle();
    end
    op(15, 0, 0, 0, 0);
    cycle();
    chk("div_lo", o_alu, 32'hFFFF_FFFD);
    op(14, 0, 0, 0, 0);
    cycle();
    chk("div_hi", o_alu, 32'hFFFF_FFFF);
    op(13, 0, 9, 0, 0);
    cycle();
    read_hl(15, n);
    chk("div0_lo", o_alu, 32'hFFFF_FFFF);
    read_hl(14, n);
    chk("div0_hi", o_alu, 9);
    op(12, 0, $urandom, $urandom, 0);
    cycle();
    repeat (10) begin
      op(1, 0, $urandom, $urandom, 0);
      cycle();
    end
    rst = 1;
    op(0, 0, 1, 2, 0);
    cycle();
    rst = 0;
    op(15, 0, 0, 0, 0);
    cycle();
    chk("rst_stall", 32'(last_stall), 0);
    chk("rst_lo", o_alu, 0);
    op(14, 0, 0, 0, 0);
    cycle();
    chk("rst_hi", o_alu, 0);
    op(12, 0, 123456, 32'(-789), 0);
    cycle();
    read_hl(15, n);
    chk("mult2_lo", o_alu, 32'(-97406784));
    read_hl(14, n);
    chk("mult2_hi", o_alu, 32'hFFFF_FFFF);
    repeat (500) begin
      rand_ins();
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
